axis_ram_writer_radar: RTL and testbench

//  Write-side counterpart of the radar RAM reader: buffers an AXI4-Stream of samples, then writes them to DDR as

---
 rtl/axis_ram_writer_radar.sv | 149 ++++++++++++++
 tb/tb_axis_ram_writer_radar.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_ram_writer_radar.sv
// Buffers an AXI4-Stream in a FWFT FIFO and drains it to DDR as fixed 16-beat INCR bursts.
// The burst index walks a cfg-selected quarter and wraps exactly like the radar RAM reader.
module axis_ram_writer_radar #(
  parameter int ADDR_WIDTH       = 16,
  parameter int AXI_ID_WIDTH     = 6,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int FIFO_WRITE_DEPTH = 512
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXI_ADDR_WIDTH-1:0]     min_addr,
  input  logic [ADDR_WIDTH-1:0]         cfg_data,
  output logic [ADDR_WIDTH-1:0]         sts_data,
  output logic                          sts_err,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [3:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic [3:0]                    m_axi_awcache,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_wid,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready
);

  localparam int ADDR_SIZE   = $clog2(AXI_DATA_WIDTH / 8);
  localparam int PTR_WIDTH   = $clog2(FIFO_WRITE_DEPTH);
  localparam int COUNT_WIDTH = PTR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

  state_t                      state, next_state;
  logic [ADDR_WIDTH-1:0]       idx, limit;
  logic [4:0]                  beat_cnt;
  logic                        aw_done;
  logic                        aw_hs, w_hs;

  // Input FIFO: first-word-fall-through, head word is presented directly on wdata.
  logic [AXIS_TDATA_WIDTH-1:0] fifo_mem [FIFO_WRITE_DEPTH];
  logic [COUNT_WIDTH-1:0]      wr_ptr, rd_ptr, fifo_count;
  logic                        fifo_full, fifo_empty, fifo_wr_en, fifo_rd_en;

  assign fifo_count    = wr_ptr - rd_ptr;
  assign fifo_full     = (fifo_count == COUNT_WIDTH'(FIFO_WRITE_DEPTH));
  assign fifo_empty    = (fifo_count == '0);
  assign s_axis_tready = ~fifo_full & ~areset;
  assign fifo_wr_en    = s_axis_tvalid & s_axis_tready;
  assign fifo_rd_en    = w_hs;

  // NOTE: storage arrays carry no reset; emptiness is defined by the pointers alone,
  // which keeps the array mappable to block RAM.
  always_ff @(posedge aclk) begin
    if (fifo_wr_en) fifo_mem[wr_ptr[PTR_WIDTH-1:0]] <= s_axis_tdata;
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr_en) wr_ptr <= wr_ptr + COUNT_WIDTH'(1);
      if (fifo_rd_en) rd_ptr <= rd_ptr + COUNT_WIDTH'(1);
    end
  end

  // NOTE: all combinational outputs get a default before the case so no path
  // leaves them unassigned (which would infer latches).
  always_comb begin
    next_state    = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    case (state)
      IDLE: if (fifo_count >= COUNT_WIDTH'(16)) next_state = BURST;
      BURST: begin
        m_axi_awvalid = ~aw_done;
        m_axi_wvalid  = ~fifo_empty & ~beat_cnt[4];
        if ((aw_done | m_axi_awready) &&
            (beat_cnt[4] | (m_axi_wvalid & m_axi_wready & (beat_cnt == 5'd15))))
          next_state = RESP;
      end
      RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      idx      <= '0;
      limit    <= '0;
      beat_cnt <= '0;
      aw_done  <= 1'b0;
      sts_err  <= 1'b0;
    end else begin
      state <= next_state;
      if (aw_hs) begin
        aw_done <= 1'b1;
        // cfg_data is only looked at on wrap, so mid-pass changes land at the next pass.
        if (idx < limit) begin
          idx <= idx + ADDR_WIDTH'(1);
        end else begin
          idx   <= {cfg_data[ADDR_WIDTH-1 -: 2], {(ADDR_WIDTH-2){1'b0}}};
          limit <= cfg_data;
        end
      end
      if (w_hs) beat_cnt <= beat_cnt + 5'd1;
      if (state == RESP && m_axi_bvalid) begin
        beat_cnt <= '0;
        aw_done  <= 1'b0;
        if (m_axi_bresp != 2'b00) sts_err <= 1'b1;
      end
    end
  end

  assign sts_data      = idx;
  assign m_axi_awaddr  = min_addr + AXI_ADDR_WIDTH'({idx, 4'd0, {ADDR_SIZE{1'b0}}});
  assign m_axi_awid    = '0;
  assign m_axi_awlen   = 4'd15;
  assign m_axi_awsize  = 3'(ADDR_SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0110;
  assign m_axi_wid     = '0;
  assign m_axi_wdata   = fifo_mem[rd_ptr[PTR_WIDTH-1:0]];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (beat_cnt == 5'd15);

endmodule

// File: tb/tb_axis_ram_writer_radar.sv
// Randomized bench for axis_ram_writer_radar: a stream source and AXI3 slave with
// adjustable readiness, and an index/address model built from the buffer-walk rules.
module tb_axis_ram_writer_radar;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] min_addr = '0;
  logic [15:0] cfg_data = '0;
  logic [15:0] sts_data;
  logic        sts_err;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [5:0]  m_axi_awid, m_axi_wid;
  logic [3:0]  m_axi_awlen, m_axi_awcache;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid, m_axi_wlast, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp = 2'b00;

  always #5 aclk = ~aclk;

  axis_ram_writer_radar dut (
    .aclk(aclk), .areset(areset), .min_addr(min_addr), .cfg_data(cfg_data),
    .sts_data(sts_data), .sts_err(sts_err),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int vectors = 0;
  int miscompares = 0;

  // Environment knobs (written by the test sequence only)
  bit          bfm_en = 1'b0;
  int          s_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100;
  int          err_burst = -1;
  logic [63:0] src_data [$];

  // Observations (written by the environment process only)
  int          src_ptr = 0, b_cnt = 0, proto_err = 0;
  logic [31:0] aw_q [$];
  logic [15:0] aw_cfg_q [$];
  logic [63:0] w_q [$];
  bit          wl_q [$];

  // Model results
  logic [31:0] exp_addr_q [$];
  logic [15:0] m_final_idx;

  function automatic bit rnd(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // Inputs change on the falling edge; handshakes seen then complete on the next rising
  // edge and are committed to the observation queues at the falling edge after that.
  bit          p_s, p_aw, p_w, p_b, p_wlast;
  logic [31:0] p_awaddr;
  logic [15:0] p_cfg;
  logic [63:0] p_wdata;
  always @(negedge aclk) begin
    if (!bfm_en) begin
      src_ptr = 0; b_cnt = 0; proto_err = 0;
      aw_q.delete(); aw_cfg_q.delete(); w_q.delete(); wl_q.delete();
    end
    if (areset || !bfm_en) begin
      {p_s, p_aw, p_w, p_b} = '0;
      s_axis_tvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    end else begin
      if (p_s) src_ptr++;
      if (p_aw) begin
        if (aw_q.size() > b_cnt) proto_err++;
        aw_q.push_back(p_awaddr); aw_cfg_q.push_back(p_cfg);
      end
      if (p_w) begin
        w_q.push_back(p_wdata); wl_q.push_back(p_wlast);
        if (w_q.size() > 16 * (b_cnt + 1)) proto_err++;
      end
      if (p_b) b_cnt++;
      if (!(s_axis_tvalid && !p_s)) begin
        if (src_ptr < src_data.size() && rnd(s_pct)) begin
          s_axis_tvalid = 1'b1; s_axis_tdata = src_data[src_ptr];
        end else s_axis_tvalid = 1'b0;
      end
      m_axi_awready = rnd(aw_pct);
      m_axi_wready  = rnd(w_pct);
      if (!(m_axi_bvalid && !p_b)) begin
        if (w_q.size() >= 16 * (b_cnt + 1) && rnd(b_pct)) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        end else m_axi_bvalid = 1'b0;
      end
      p_s  = s_axis_tvalid & s_axis_tready;
      p_aw = m_axi_awvalid & m_axi_awready; p_awaddr = m_axi_awaddr; p_cfg = cfg_data;
      p_w  = m_axi_wvalid & m_axi_wready; p_wdata = m_axi_wdata; p_wlast = m_axi_wlast;
      p_b  = m_axi_bvalid & m_axi_bready;
    end
  end

  // Buffer walk: first burst at 0, then step through the quarter and wrap using the
  // cfg value present when the wrapping burst's address was accepted.
  task automatic build_model();
    logic [15:0] m_idx = '0;
    logic [15:0] m_lim = '0;
    exp_addr_q.delete();
    foreach (aw_cfg_q[k]) begin
      exp_addr_q.push_back(min_addr + 32'(m_idx) * 32'd128);
      if (m_idx < m_lim) m_idx = m_idx + 16'd1;
      else begin
        m_idx = {aw_cfg_q[k][15:14], 14'd0};
        m_lim = aw_cfg_q[k];
      end
    end
    m_final_idx = m_idx;
  endtask

  task automatic apply_reset();
    bfm_en = 1'b0;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #2 areset = 1'b0;
    @(posedge aclk); #2;
  endtask

  task automatic wait_for(input int n_w, input int n_b, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge aclk); #2;
      if (w_q.size() >= n_w && b_cnt >= n_b) begin ok = 1'b1; break; end
    end
  endtask

  task automatic load_ramp(input int n, input logic [63:0] base);
    src_data.delete();
    for (int i = 0; i < n; i++) src_data.push_back(base + 64'(i));
  endtask

  task automatic test_reset();
    areset = 1'b1; bfm_en = 1'b0;
    repeat (2) @(posedge aclk); #2;
    vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready}); end
    vectors++; if (sts_data !== 16'h0 || sts_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_sts: got %h/%b want 0000/0", sts_data, sts_err); end
    vectors++; if ({m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wid, m_axi_wstrb}
                   !== {6'd0, 4'd15, 3'd3, 2'b01, 4'b0110, 6'd0, 8'hFF}) begin
      miscompares++; $display("FAIL const_fields: got id%0d len%0d size%0d burst%0d cache%0d wid%0d strb%h",
        m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wid, m_axi_wstrb); end
    #3 areset = 1'b0;
    @(posedge aclk); #2;
    vectors++; if (s_axis_tready !== 1'b1 || m_axi_awvalid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset: got tready=%b awvalid=%b want 1/0", s_axis_tready, m_axi_awvalid); end
  endtask

  task automatic test_basic_stream();
    bit ok;
    cfg_data = 16'h0003; min_addr = 32'h1000_0000;
    {s_pct, aw_pct, w_pct, b_pct} = {32'd100, 32'd100, 32'd100, 32'd100};
    load_ramp(64, 64'd0);
    apply_reset(); bfm_en = 1'b1;
    wait_for(64, 4, 3000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL t1_timeout: got %0d beats %0d B want 64/4", w_q.size(), b_cnt); end
    repeat (20) @(posedge aclk); #2;
    build_model();
    vectors++; if (aw_q.size() !== 4 || w_q.size() !== 64) begin
      miscompares++; $display("FAIL t1_counts: got aw=%0d w=%0d want 4/64", aw_q.size(), w_q.size()); end
    foreach (w_q[i]) begin
      vectors++; if (w_q[i] !== src_data[i] || wl_q[i] !== (i % 16 == 15)) begin
        miscompares++; $display("FAIL t1_beat[%0d]: got %h last=%b want %h last=%b", i, w_q[i], wl_q[i], src_data[i], i % 16 == 15); end
    end
    foreach (aw_q[k]) begin
      vectors++; if (aw_q[k] !== exp_addr_q[k]) begin
        miscompares++; $display("FAIL t1_awaddr[%0d]: got %h want %h", k, aw_q[k], exp_addr_q[k]); end
    end
    vectors++; if (sts_data !== m_final_idx || proto_err !== 0) begin
      miscompares++; $display("FAIL t1_sts: got idx=%h proto=%0d want %h/0", sts_data, proto_err, m_final_idx); end
  endtask

  task automatic test_quarter_wrap();
    bit ok;
    cfg_data = 16'h4002; min_addr = 32'h2000_0040;
    load_ramp(80, 64'h100);
    apply_reset(); bfm_en = 1'b1;
    wait_for(80, 5, 3000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL t2_timeout: got %0d beats %0d B want 80/5", w_q.size(), b_cnt); end
    build_model();
    vectors++; if (aw_q.size() !== 5) begin miscompares++; $display("FAIL t2_aw_count: got %0d want 5", aw_q.size()); end
    foreach (aw_q[k]) begin
      vectors++; if (aw_q[k] !== exp_addr_q[k]) begin
        miscompares++; $display("FAIL t2_awaddr[%0d]: got %h want %h", k, aw_q[k], exp_addr_q[k]); end
    end
    vectors++; if (sts_data !== m_final_idx) begin miscompares++; $display("FAIL t2_sts_data: got %h want %h", sts_data, m_final_idx); end
  endtask

  task automatic test_backpressure();
    bit ok;
    cfg_data = {2'($urandom), 14'($urandom_range(3))};
    min_addr = 32'hFFFF_F000 | ($urandom & 32'h0000_0FF8);
    {s_pct, aw_pct, w_pct, b_pct} = {32'd70, 32'd35, 32'd50, 32'd40};
    src_data.delete();
    for (int i = 0; i < 320; i++) src_data.push_back({$urandom, $urandom});
    apply_reset(); bfm_en = 1'b1;
    wait_for(160, 10, 8000, ok);
    cfg_data = {2'($urandom), 14'($urandom_range(3))};
    wait_for(320, 20, 8000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL t3_timeout: got %0d beats %0d B want 320/20", w_q.size(), b_cnt); end
    repeat (40) @(posedge aclk); #2;
    build_model();
    vectors++; if (aw_q.size() !== 20 || w_q.size() !== 320 || proto_err !== 0) begin
      miscompares++; $display("FAIL t3_counts: got aw=%0d w=%0d proto=%0d want 20/320/0", aw_q.size(), w_q.size(), proto_err); end
    foreach (w_q[i]) begin
      vectors++; if (w_q[i] !== src_data[i] || wl_q[i] !== (i % 16 == 15)) begin
        miscompares++; $display("FAIL t3_beat[%0d]: got %h last=%b want %h last=%b", i, w_q[i], wl_q[i], src_data[i], i % 16 == 15); end
    end
    foreach (aw_q[k]) begin
      vectors++; if (aw_q[k] !== exp_addr_q[k]) begin
        miscompares++; $display("FAIL t3_awaddr[%0d]: got %h want %h", k, aw_q[k], exp_addr_q[k]); end
    end
  endtask

  task automatic test_fifo_full();
    bit ok, dropped;
    cfg_data = 16'h0000; min_addr = 32'h0;
    {s_pct, aw_pct, w_pct, b_pct} = {32'd100, 32'd0, 32'd0, 32'd100};
    load_ramp(600, 64'h5000);
    apply_reset(); bfm_en = 1'b1;
    dropped = 1'b0;
    for (int c = 0; c < 2000 && !dropped; c++) begin
      @(posedge aclk); #2;
      dropped = !s_axis_tready;
    end
    repeat (10) @(posedge aclk); #2;
    vectors++; if (!dropped || s_axis_tready !== 1'b0) begin
      miscompares++; $display("FAIL t4_tready_drop: got dropped=%b tready=%b want 1/0", dropped, s_axis_tready); end
    vectors++; if (src_ptr !== 512 || w_q.size() !== 0) begin
      miscompares++; $display("FAIL t4_accepted: got %0d in %0d out want 512/0", src_ptr, w_q.size()); end
    aw_pct = 100; w_pct = 100;
    wait_for(592, 37, 4000, ok);
    vectors++; if (!ok || src_ptr !== 600) begin
      miscompares++; $display("FAIL t4_drain: got %0d beats %0d in want 592/600", w_q.size(), src_ptr); end
    foreach (w_q[i]) begin
      vectors++; if (w_q[i] !== src_data[i]) begin
        miscompares++; $display("FAIL t4_beat[%0d]: got %h want %h", i, w_q[i], src_data[i]); end
    end
  endtask

  task automatic test_bresp_err();
    bit ok;
    cfg_data = 16'h0003; min_addr = 32'h3000_0000;
    {s_pct, aw_pct, w_pct, b_pct} = {32'd100, 32'd100, 32'd100, 32'd60};
    err_burst = 1;
    load_ramp(64, 64'h9000);
    apply_reset(); bfm_en = 1'b1;
    wait_for(16, 1, 2000, ok);
    vectors++; if (!ok || sts_err !== 1'b0) begin miscompares++; $display("FAIL t5_err_after_b1: got ok=%b err=%b want 1/0", ok, sts_err); end
    wait_for(32, 2, 2000, ok);
    vectors++; if (!ok || sts_err !== 1'b1) begin miscompares++; $display("FAIL t5_err_after_b2: got ok=%b err=%b want 1/1", ok, sts_err); end
    wait_for(64, 4, 3000, ok);
    vectors++; if (!ok || sts_err !== 1'b1 || aw_q.size() !== 4) begin
      miscompares++; $display("FAIL t5_sticky: got ok=%b err=%b aw=%0d want 1/1/4", ok, sts_err, aw_q.size()); end
    foreach (w_q[i]) begin
      vectors++; if (w_q[i] !== src_data[i]) begin miscompares++; $display("FAIL t5_beat[%0d]: got %h want %h", i, w_q[i], src_data[i]); end
    end
    err_burst = -1;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    cfg_data = 16'h0003; min_addr = 32'h4000_0000;
    {s_pct, aw_pct, w_pct, b_pct} = {32'd100, 32'd0, 32'd100, 32'd100};
    load_ramp(32, 64'hDEAD_0000);
    apply_reset(); bfm_en = 1'b1;
    wait_for(7, 0, 2000, ok);
    vectors++; if (!ok || m_axi_awvalid !== 1'b1) begin miscompares++; $display("FAIL t6_pre: got ok=%b awvalid=%b want 1/1", ok, m_axi_awvalid); end
    areset = 1'b1; bfm_en = 1'b0;
    #1;
    vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready} !== 4'b0 || sts_data !== 16'h0) begin
      miscompares++; $display("FAIL t6_abort: got ctrl=%b idx=%h want 0000/0000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready}, sts_data); end
    repeat (2) @(posedge aclk);
    load_ramp(16, 64'hBEEF_0000);
    aw_pct = 100;
    #2 areset = 1'b0;
    @(posedge aclk); #2;
    bfm_en = 1'b1;
    wait_for(16, 1, 2000, ok);
    repeat (20) @(posedge aclk); #2;
    vectors++; if (!ok || aw_q.size() !== 1 || w_q.size() !== 16) begin
      miscompares++; $display("FAIL t6_restart: got ok=%b aw=%0d w=%0d want 1/1/16", ok, aw_q.size(), w_q.size()); end
    vectors++; if (aw_q.size() > 0 && aw_q[0] !== min_addr) begin
      miscompares++; $display("FAIL t6_addr: got %h want %h", aw_q[0], min_addr); end
    foreach (w_q[i]) begin
      vectors++; if (w_q[i] !== src_data[i]) begin miscompares++; $display("FAIL t6_beat[%0d]: got %h want %h", i, w_q[i], src_data[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_quarter_wrap();
    test_backpressure();
    test_fifo_full();
    test_bresp_err();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion want finish before 3ms");
    $fatal(1);
  end

endmodule
